mem_write_monitor: RTL and testbench

// - Parametrised debug monitor for store traffic of the RISC-V core.
// - Captures address-windowed mem_write events (addr, data) into a DEPTH-entry FIFO.
// - Replays entries one at a time through a sequential binary-to-BCD converter.
// - BCD digits feed dig_displ_7_segs instances on the board top.
// - Advance mode selectable at run time: AUTO (timer) or MANUAL (step pulse).
//

---
 rtl/mem_write_monitor.sv | 209 ++++++++++++++++++++
 tb/tb_mem_write_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_monitor.sv
// Store-traffic debug monitor: captures windowed core writes into a small FIFO and
// replays each entry through a sequential binary-to-BCD converter for 7-segment display.
//
// state  | meaning
// S_IDLE | nothing shown yet, waiting for the first captured entry
// S_LOAD | pop FIFO head into the shift registers, clear BCD accumulators
// S_CONV | one double-dabble iteration per cycle on address and data
// S_SHOW | converted entry on display, waiting for an advance request
module mem_write_monitor #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           CAP_AW      = 10,
  parameter int unsigned           CAP_DW      = 10,
  parameter int unsigned           ADDR_DIGITS = 4,
  parameter int unsigned           DATA_DIGITS = 4,
  parameter int unsigned           DEPTH       = 8,
  parameter logic [DATA_WIDTH-1:0] ADDR_LO     = '0,
  parameter logic [DATA_WIDTH-1:0] ADDR_HI     = DATA_WIDTH'('hFFF),
  parameter int unsigned           HOLD_CYCLES = 50000000
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        mem_write_i,
  input  logic [DATA_WIDTH-1:0]       data_addr_i,
  input  logic [DATA_WIDTH-1:0]       write_data_i,
  input  logic                        mode_i,
  input  logic                        step_i,
  input  logic                        clear_i,
  output logic [4*ADDR_DIGITS-1:0]    disp_addr_o,
  output logic [4*DATA_DIGITS-1:0]    disp_data_o,
  output logic                        disp_valid_o,
  output logic [$clog2(DEPTH):0]      fifo_count_o,
  output logic                        overflow_o
);

  localparam int unsigned CONV_W = (CAP_AW > CAP_DW) ? CAP_AW : CAP_DW;
  localparam int unsigned EW     = CAP_AW + CAP_DW;
  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned IW     = $clog2(CONV_W + 1);
  localparam int unsigned TW     = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned AB     = 4 * ADDR_DIGITS;
  localparam int unsigned DB     = 4 * DATA_DIGITS;
  localparam logic [DATA_WIDTH-1:0] WIN_SPAN = ADDR_HI - ADDR_LO;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  if (pow10(ADDR_DIGITS) <= ((64'd1 << CAP_AW) - 64'd1)) begin : g_bad_addr_digits
    $error("ADDR_DIGITS too small for CAP_AW");
  end
  if (pow10(DATA_DIGITS) <= ((64'd1 << CAP_DW) - 64'd1)) begin : g_bad_data_digits
    $error("DATA_DIGITS too small for CAP_DW");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV, S_SHOW} state_e;

  state_e              state_q;
  logic [EW-1:0]       fifo_mem [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic                overflow_q;
  logic [CONV_W-1:0]   sh_a_q, sh_d_q;
  logic [AB-1:0]       bcd_a_q, bcd_a_adj, bcd_a_d;
  logic [DB-1:0]       bcd_d_q, bcd_d_adj, bcd_d_d;
  logic [IW-1:0]       iter_q;
  logic [TW-1:0]       timer_q;
  logic [AB-1:0]       disp_addr_q;
  logic [DB-1:0]       disp_data_q;
  logic                disp_valid_q;

  logic                in_win, push_req, push_acc, pop, full, advance;
  logic [EW-1:0]       head;
  logic                unused_wdata;

  // Single unsigned compare covers both window bounds without a constant-true check at ADDR_LO=0.
  assign in_win   = (data_addr_i - ADDR_LO) <= WIN_SPAN;
  assign push_req = mem_write_i && in_win && !clear_i;
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = (state_q == S_LOAD) && !clear_i;
  assign push_acc = push_req && (!full || pop);
  assign head     = fifo_mem[rd_ptr_q];
  assign advance  = mode_i ? step_i : (timer_q == TW'(HOLD_CYCLES - 1));
  assign unused_wdata = ^write_data_i[DATA_WIDTH-1:CAP_DW];

  always_ff @(posedge clk_i) begin
    if (push_acc) fifo_mem[wr_ptr_q] <= {data_addr_i[CAP_AW-1:0], write_data_i[CAP_DW-1:0]};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_acc, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_req && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    bcd_a_adj = bcd_a_q;
    for (int i = 0; i < int'(ADDR_DIGITS); i++) begin
      if (bcd_a_q[4*i +: 4] >= 4'd5) bcd_a_adj[4*i +: 4] = bcd_a_q[4*i +: 4] + 4'd3;
    end
    bcd_d_adj = bcd_d_q;
    for (int i = 0; i < int'(DATA_DIGITS); i++) begin
      if (bcd_d_q[4*i +: 4] >= 4'd5) bcd_d_adj[4*i +: 4] = bcd_d_q[4*i +: 4] + 4'd3;
    end
    bcd_a_d = {bcd_a_adj[AB-2:0], sh_a_q[CONV_W-1]};
    bcd_d_d = {bcd_d_adj[DB-2:0], sh_d_q[CONV_W-1]};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      sh_a_q       <= '0;
      sh_d_q       <= '0;
      bcd_a_q      <= '0;
      bcd_d_q      <= '0;
      iter_q       <= '0;
      timer_q      <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else if (clear_i) begin
      state_q      <= S_IDLE;
      sh_a_q       <= '0;
      sh_d_q       <= '0;
      bcd_a_q      <= '0;
      bcd_d_q      <= '0;
      iter_q       <= '0;
      timer_q      <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (count_q != '0) state_q <= S_LOAD;
        end
        S_LOAD: begin
          sh_a_q  <= CONV_W'(head[EW-1:CAP_DW]);
          sh_d_q  <= CONV_W'(head[CAP_DW-1:0]);
          bcd_a_q <= '0;
          bcd_d_q <= '0;
          iter_q  <= '0;
          state_q <= S_CONV;
        end
        S_CONV: begin
          sh_a_q  <= sh_a_q << 1;
          sh_d_q  <= sh_d_q << 1;
          bcd_a_q <= bcd_a_d;
          bcd_d_q <= bcd_d_d;
          // The last iteration's result goes straight to the display registers.
          if (iter_q == IW'(CONV_W - 1)) begin
            disp_addr_q  <= bcd_a_d;
            disp_data_q  <= bcd_d_d;
            disp_valid_q <= 1'b1;
            timer_q      <= '0;
            state_q      <= S_SHOW;
          end else begin
            iter_q <= iter_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (advance) begin
            timer_q <= '0;
            if (count_q != '0) state_q <= S_LOAD;
          end else if (!mode_i) begin
            timer_q <= timer_q + 1'b1;
          end else begin
            timer_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign disp_addr_o  = disp_addr_q;
  assign disp_data_o  = disp_data_q;
  assign disp_valid_o = disp_valid_q;
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor with hand-computed BCD and timing expectations.
module tb_mem_write_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_write;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic        mode;
  logic        step;
  logic        clear;
  logic [15:0] disp_addr;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic [3:0]  fifo_count;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  mem_write_monitor #(
    .DATA_WIDTH(32), .CAP_AW(10), .CAP_DW(10), .ADDR_DIGITS(4), .DATA_DIGITS(4),
    .DEPTH(8), .ADDR_LO(32'h0), .ADDR_HI(32'hFFF), .HOLD_CYCLES(4)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .mem_write_i(mem_write), .data_addr_i(data_addr),
    .write_data_i(write_data), .mode_i(mode), .step_i(step), .clear_i(clear),
    .disp_addr_o(disp_addr), .disp_data_o(disp_data), .disp_valid_o(disp_valid),
    .fifo_count_o(fifo_count), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write  = 1'b1;
    data_addr  = a;
    write_data = d;
    tick();
    mem_write  = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    int idx_pop, idx_disp, ev_n;
    int ev_t[3];
    logic [15:0] ev_a[3], ev_d[3];
    logic [15:0] last_a;
    logic        last_v;

    reset_n = 1'b0; mem_write = 1'b0; data_addr = '0; write_data = '0;
    mode = 1'b1; step = 1'b0; clear = 1'b0;
    repeat (2) tick();
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_valid", 32'(disp_valid), 0);
    chk("rst_daddr", 32'(disp_addr), 0);
    chk("rst_ddata", 32'(disp_data), 0);
    reset_n = 1'b1;
    tick();

    // first capture and conversion latency, MANUAL mode
    store(32'h07C, 32'h019);
    idx_pop = -1; idx_disp = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (idx_pop < 0 && fifo_count == 0) idx_pop = k;
      if (disp_valid) begin
        idx_disp = k;
        break;
      end
    end
    chk("pop_to_disp", 32'(idx_disp - idx_pop + 1), 11);
    chk("first_addr", 32'(disp_addr), 32'h0124);
    chk("first_data", 32'(disp_data), 32'h0025);
    chk("first_valid", 32'(disp_valid), 1);

    // window boundaries
    store(32'h1000, 32'h055);
    chk("outwin_count", 32'(fifo_count), 0);
    chk("outwin_disp", 32'(disp_addr), 32'h0124);
    store(32'hFFF, 32'h3FF);
    store(32'h005, 32'h007);
    chk("inwin_count", 32'(fifo_count), 2);

    // step during CONV must not cause a second advance
    pulse_step();
    tick();
    tick();
    tick();
    pulse_step();
    repeat (20) tick();
    chk("convstep_count", 32'(fifo_count), 1);
    chk("max_addr", 32'(disp_addr), 32'h1023);
    chk("max_data", 32'(disp_data), 32'h1023);

    pulse_step();
    repeat (15) tick();
    chk("step2_addr", 32'(disp_addr), 32'h0005);
    chk("step2_data", 32'(disp_data), 32'h0007);
    chk("step2_count", 32'(fifo_count), 0);

    pulse_step();
    repeat (15) tick();
    chk("empty_step_addr", 32'(disp_addr), 32'h0005);
    chk("empty_step_data", 32'(disp_data), 32'h0007);
    chk("empty_step_valid", 32'(disp_valid), 1);

    // fill, overflow, push with simultaneous pop, clear mid-CONV
    for (int i = 0; i < 8; i++) store(32'h100 + 32'(i), 32'(i));
    chk("full_count", 32'(fifo_count), 8);
    chk("full_no_ovf", 32'(overflow), 0);
    store(32'h200, 32'h1);
    chk("ovf_count", 32'(fifo_count), 8);
    chk("ovf_set", 32'(overflow), 1);
    pulse_step();
    store(32'h201, 32'h2);
    chk("push_pop_count", 32'(fifo_count), 8);
    tick();
    tick();
    clear = 1'b1;
    store(32'h010, 32'h3);
    clear = 1'b0;
    chk("clr_count", 32'(fifo_count), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_valid", 32'(disp_valid), 0);
    chk("clr_daddr", 32'(disp_addr), 0);
    repeat (15) tick();
    chk("abort_valid", 32'(disp_valid), 0);
    chk("abort_daddr", 32'(disp_addr), 0);
    chk("abort_count", 32'(fifo_count), 0);

    // AUTO mode: 4 SHOW cycles + 1 LOAD + 10 CONV between display updates
    mode = 1'b0;
    store(32'd1, 32'd11);
    store(32'd2, 32'd22);
    store(32'd3, 32'd33);
    ev_n = 0; last_a = disp_addr; last_v = disp_valid;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (disp_valid && (!last_v || disp_addr != last_a)) begin
        if (ev_n < 3) begin
          ev_t[ev_n] = k;
          ev_a[ev_n] = disp_addr;
          ev_d[ev_n] = disp_data;
        end
        ev_n++;
      end
      last_a = disp_addr;
      last_v = disp_valid;
    end
    chk("auto_events", 32'(ev_n), 3);
    chk("auto_a0", 32'(ev_a[0]), 32'h0001);
    chk("auto_d0", 32'(ev_d[0]), 32'h0011);
    chk("auto_a1", 32'(ev_a[1]), 32'h0002);
    chk("auto_d1", 32'(ev_d[1]), 32'h0022);
    chk("auto_a2", 32'(ev_a[2]), 32'h0003);
    chk("auto_d2", 32'(ev_d[2]), 32'h0033);
    chk("auto_gap01", 32'(ev_t[1] - ev_t[0]), 15);
    chk("auto_gap12", 32'(ev_t[2] - ev_t[1]), 15);
    chk("auto_end_count", 32'(fifo_count), 0);

    // async reset in the middle of a conversion
    store(32'd20, 32'd30);
    tick();
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(disp_valid), 0);
    chk("arst_daddr", 32'(disp_addr), 0);
    chk("arst_ddata", 32'(disp_data), 0);
    chk("arst_count", 32'(fifo_count), 0);
    chk("arst_ovf", 32'(overflow), 0);
    #1 reset_n = 1'b1;
    repeat (20) tick();
    chk("post_rst_valid", 32'(disp_valid), 0);
    chk("post_rst_count", 32'(fifo_count), 0);
    store(32'd42, 32'd99);
    repeat (20) tick();
    chk("post_rst_addr", 32'(disp_addr), 32'h0042);
    chk("post_rst_data", 32'(disp_data), 32'h0099);
    chk("post_rst_dvalid", 32'(disp_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
